// File: rtl/des_block_loader.sv
// DES input stage: assembles 64-bit blocks from a byte stream, applies the initial
// permutation and hands L0/R0 to the round engine through a one-entry output register.
module des_block_loader #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] l_out,
  output logic [31:0] r_out,
  output logic        busy
);

  logic [2:0]  r_cnt;
  logic [63:0] r_blk;
  logic        r_out_valid;
  logic [31:0] r_l_out;
  logic [31:0] r_r_out;

  logic        w_xfer;
  logic        w_complete;
  logic [2:0]  w_pos;
  logic [63:0] w_blk_next;
  logic [63:0] w_perm;

  // Only the completing byte stalls, and only while the output slot stays occupied.
  assign in_ready   = ~((r_cnt == 3'd7) & r_out_valid & ~out_ready);
  assign w_xfer     = in_valid & in_ready & ~flush;
  assign w_complete = w_xfer & (r_cnt == 3'd7);
  assign w_pos      = MSB_FIRST ? ~r_cnt : r_cnt;

  // Incoming byte merged with the buffer so the 8th byte feeds the permutation directly.
  always_comb begin
    w_blk_next = r_blk;
    w_blk_next[{w_pos, 3'b000} +: 8] = in_data;
  end

  // Initial permutation: blk[{r, c}] moves to perm[{~c[0], c[2:1], ~r}].
  always_comb begin
    logic [5:0] v_src;
    w_perm = '0;
    for (int i = 0; i < 64; i++) begin
      v_src = 6'(i);
      w_perm[{~v_src[0], v_src[2:1], ~v_src[5:3]}] = w_blk_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 3'd0;
      r_blk       <= 64'd0;
      r_out_valid <= 1'b0;
      r_l_out     <= 32'd0;
      r_r_out     <= 32'd0;
    end else begin
      if (flush) begin
        r_cnt <= 3'd0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 3'd1;
        r_blk <= w_blk_next;
      end

      if (w_complete) begin
        r_out_valid <= 1'b1;
        r_l_out     <= w_perm[63:32];
        r_r_out     <= w_perm[31:0];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign l_out     = r_l_out;
  assign r_out     = r_r_out;
  assign busy      = (r_cnt != 3'd0) | r_out_valid;

endmodule

// File: tb/tb_des_block_loader.sv
// Randomized and directed bench for des_block_loader against a byte-level model
// that uses the standard DES IP/FP tables.
module tb_des_block_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] l_out;
  logic [31:0] r_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_cnt;
  logic [7:0]  m_bytes [8];
  bit          m_valid;
  logic [31:0] m_l;
  logic [31:0] m_r;

  des_block_loader #(.MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .l_out     (l_out),
    .r_out     (r_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Standard DES IP table position j (1-based, MSB first) takes input bit ip_src(j).
  function automatic int ip_src(input int j);
    int q, m;
    q = (j - 1) / 8;
    m = (j - 1) % 8;
    return ((q < 4) ? (58 + 2 * q) : (57 + 2 * (q - 4))) - 8 * m;
  endfunction

  function automatic logic [63:0] des_ip(input logic [63:0] b);
    logic [63:0] p;
    p = '0;
    for (int j = 1; j <= 64; j++) p[64 - j] = b[64 - ip_src(j)];
    return p;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] b);
    logic [63:0] p;
    p = '0;
    for (int j = 1; j <= 64; j++) p[64 - ip_src(j)] = b[64 - j];
    return p;
  endfunction

  function automatic logic [63:0] model_block();
    logic [63:0] blk;
    blk = '0;
    for (int k = 0; k < 8; k++) blk = (blk << 8) | 64'(m_bytes[k]);
    return blk;
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_valid = 0;
    m_l     = '0;
    m_r     = '0;
  endtask

  // One clock: drive at posedge+1, check in_ready, then update model and check outputs.
  task automatic drive(input bit v, input logic [7:0] d, input bit fl, input bit ordy,
                       output bit acc);
    bit          exp_rdy;
    bit          comp;
    logic [63:0] p;
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    #1;
    exp_rdy = !(m_cnt == 7 && m_valid && !ordy);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    comp = 0;
    if (fl) begin
      m_cnt = 0;
    end else if (acc) begin
      m_bytes[m_cnt] = d;
      if (m_cnt == 7) begin
        comp  = 1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (comp) begin
      p       = des_ip(model_block());
      m_l     = p[63:32];
      m_r     = p[31:0];
      m_valid = 1;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("busy", 64'(busy), 64'((m_cnt != 0) || m_valid));
    check("l_out", 64'(l_out), 64'(m_l));
    check("r_out", 64'(r_out), 64'(m_r));
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    drive(1'b0, 8'($urandom), 1'b0, ordy, acc);
  endtask

  // Sends one block MSB byte first; each byte retried for a bounded number of cycles.
  task automatic send_block(input logic [63:0] blk, input bit ordy);
    bit          acc;
    int          tries;
    logic [63:0] tmp;
    tmp = blk;
    for (int k = 0; k < 8; k++) begin
      tries = 0;
      acc   = 0;
      while (!acc && tries < 20) begin
        drive(1'b1, tmp[63 - 8 * k -: 8], 1'b0, ordy, acc);
        tries++;
      end
      check("send_block_timeout", 64'(acc), 64'd1);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_l_out", 64'(l_out), 64'd0);
    check("rst_r_out", 64'(r_out), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit          acc;
    int          idx;
    int          guard;
    logic [7:0]  q [$];
    logic [63:0] blk;
    logic [63:0] blk_a;
    logic [63:0] blk_b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_lr", {l_out, r_out}, 64'd0);
    rst = 1'b0;

    // Standard vector
    send_block(64'h0123456789ABCDEF, 1'b1);
    check("std_valid", 64'(out_valid), 64'd1);
    check("std_l", 64'(l_out), 64'hCC00CCFF);
    check("std_r", 64'(r_out), 64'hF0AAF0AA);
    idle(1'b1);
    check("std_drop", 64'(out_valid), 64'd0);

    // Single-bit walk with round trip through the final permutation
    for (int i = 0; i < 64; i++) begin
      blk = 64'd1 << i;
      send_block(blk, 1'b1);
      check("walk_fp", des_fp({l_out, r_out}), blk);
      if (i == 0) check("walk_bit0", {l_out, r_out}, 64'h00000080_00000000);
      if (i == 63) check("walk_bit63", {l_out, r_out}, 64'h00000000_01000000);
    end
    idle(1'b1);

    // Backpressure across two blocks
    blk_a = {$urandom, $urandom};
    blk_b = {$urandom, $urandom};
    q.delete();
    for (int k = 0; k < 8; k++) q.push_back(blk_a[63 - 8 * k -: 8]);
    for (int k = 0; k < 8; k++) q.push_back(blk_b[63 - 8 * k -: 8]);
    for (int c = 0; c < 25 && q.size() > 0; c++) begin
      drive(1'b1, q[0], 1'b0, 1'b0, acc);
      if (acc) void'(q.pop_front());
    end
    check("bp_left", 64'(q.size()), 64'd1);
    check("bp_hold", {l_out, r_out}, des_ip(blk_a));
    drive(1'b1, q[0], 1'b0, 1'b1, acc);
    check("bp_accept", 64'(acc && in_ready), 64'd1);
    check("bp_blk_b", {l_out, r_out}, des_ip(blk_b));
    check("bp_valid", 64'(out_valid), 64'd1);
    idle(1'b1);

    // Back-to-back blocks
    for (int b = 0; b < 4; b++) send_block({$urandom, $urandom}, 1'b1);
    idle(1'b1);

    // Flush with a pending output block
    blk_a = {$urandom, $urandom};
    send_block(blk_a, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    drive(1'b1, 8'hA5, 1'b1, 1'b0, acc);
    check("flush_pending", {l_out, r_out}, des_ip(blk_a));
    check("flush_valid", 64'(out_valid), 64'd1);
    blk_b = {$urandom, $urandom};
    send_block(blk_b, 1'b1);
    check("flush_next", {l_out, r_out}, des_ip(blk_b));
    idle(1'b1);

    // Async reset mid-block, then while out_valid is high
    for (int k = 0; k < 3; k++) drive(1'b1, 8'($urandom), 1'b0, 1'b1, acc);
    do_reset();
    send_block({$urandom, $urandom}, 1'b0);
    do_reset();
    blk = {$urandom, $urandom};
    send_block(blk, 1'b1);
    check("post_reset_blk", {l_out, r_out}, des_ip(blk));

    // Random traffic
    guard = 0;
    for (int c = 0; c < 800; c++) begin
      idx = $urandom_range(0, 15);
      drive(1'($urandom), 8'($urandom), (idx == 0), ($urandom_range(0, 3) != 0), acc);
      guard++;
    end
    check("random_cycles", 64'(guard), 64'd800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_block_loader.md
Name: des_block_loader

Overview:
- Input stage of the DES datapath, and the counterpart of the final-permutation output stage.
- Accepts an 8-bit plaintext/ciphertext byte stream over a valid/ready handshake and assembles 64-bit blocks.
- Applies the DES initial permutation (IP) to each block and presents L0/R0 halves to the round engine through a one-entry output register with valid/ready.
- Assembly of the next block overlaps with the round engine holding the current one.

Parameters:
- MSB_FIRST, 1: 1 = first byte received lands in blk[63:56] (standard DES order); 0 = first byte lands in blk[7:0].

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a valid byte.
- in_ready  output  1  loader can accept a byte this cycle.
- in_data  input  8  byte stream.
- flush  input  1  discard any partially assembled block.
- out_valid  output  1  l_out/r_out hold a permuted block.
- out_ready  input  1  round engine takes the block.
- l_out  output  32  perm[63:32] (L0).
- r_out  output  32  perm[31:0] (R0).
- busy  output  1  byte count nonzero or out_valid high.

Behaviour:
- Reset (async, immediate):
  - byte count = 0, out_valid = 0, l_out = 0, r_out = 0, busy = 0.
  - Assembly buffer cleared to 0.
  - in_ready is 1 on the first cycle after reset deasserts.
- Byte transfer occurs when in_valid & in_ready at a clock edge. Byte k (k = 0..7) is written to:
  - MSB_FIRST = 1: blk[63-8k -: 8]
  - MSB_FIRST = 0: blk[8k +: 8]
- Count: 3-bit, increments per transfer and wraps 7 -> 0 on the 8th byte.
- IP definition, bit 0 = LSB: for r, c in 0..7, perm[{~c[0], c[2:1], ~r[2:0]}] = blk[{r, c}].
  - Example: blk[0] -> perm[39], blk[63] -> perm[24].
  - This is exactly the inverse of the final permutation used at the output stage.
- Completion: on the edge that transfers byte 7, the permuted value of the completed block is loaded into l_out/r_out and out_valid is set. The 8th byte is combined with bytes 0..6 directly, not via a registered buffer.
  - Latency: out_valid rises in the cycle after the 8th transfer.
- Output handshake:
  - out_valid clears on the edge where out_valid & out_ready, unless a new block completes on the same edge.
  - If a new block completes on that edge, out_valid stays 1 and the new block is loaded (back-to-back throughput: one block per 8 cycles).
  - l_out/r_out are held stable while out_valid & ~out_ready.
- Backpressure: in_ready = ~(count == 7 & out_valid & ~out_ready). Bytes 0..6 of the next block are always accepted; only the completing byte stalls.
- flush:
  - Synchronous; sets count to 0 and ignores any same-cycle byte transfer.
  - Does not affect out_valid, l_out or r_out.
  - in_ready is unaffected by flush.
- busy = (count != 0) | out_valid.
- in_data is ignored when in_valid = 0. The assembly buffer is not cleared between blocks; stale bytes are always overwritten before use.
- Reset asserted mid-block or while out_valid is high discards everything; no partial output is ever presented.

Test Plan:
- Standard vector: MSB_FIRST=1, bytes 01 23 45 67 89 AB CD EF on consecutive cycles, out_ready=1 -> one cycle after the 8th byte, out_valid=1, l_out=CC00CCFF, r_out=F0AAF0AA; out_valid drops the next cycle.
- Single-bit walk: blk = 64'h1 (only blk[0] set) -> perm bit 39 only, so l_out=00000080, r_out=00000000. Repeat for all 64 single-bit positions against the closed-form mapping; applying the final permutation to the output must return the input.
- Backpressure: hold out_ready=0, stream two blocks -> first block held stable; in_ready drops when count=7; 8th byte of block 2 is accepted on the cycle out_ready rises; no byte lost or duplicated.
- Back-to-back: continuous in_valid=1, out_ready=1 over 4 blocks -> in_ready stays 1 and out_valid pulses every 8 cycles with the correct permuted values.
- Flush: send 5 bytes, assert flush with in_valid=1 -> that byte is dropped and count=0; the next 8 bytes form a correct block. A pending out_valid block is untouched.
- Async reset: assert rst mid-block and while out_valid=1 -> out_valid, busy, l_out and r_out go to 0 immediately; the following 8 bytes form a correct block.
